// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver (start / DATA_BITS LSB-first / stop)
//                with framing-error reporting and receiver enable.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 baud_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = $clog2(DATA_BITS + 1);

   localparam logic [1:0] c_IDLE  = 2'd0;
   localparam logic [1:0] c_START = 2'd1;
   localparam logic [1:0] c_DATA  = 2'd2;
   localparam logic [1:0] c_STOP  = 2'd3;

   localparam logic [TICK_W-1:0] c_TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TICK_W-1:0] c_TICK_LAST = TICK_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  c_LAST_BIT  = BIT_W'(DATA_BITS - 1);

   logic                 r_rx_meta;
   logic                 r_rx_s;
   logic                 r_rx_prev;
   logic [1:0]           r_state;
   logic [TICK_W-1:0]    r_tick_cnt;
   logic [BIT_W-1:0]     r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_valid;
   logic                 r_frame_err;

   logic                 w_fall;
   logic [DATA_BITS-1:0] w_shift_next;

   // The edge detector tracks rx_s every clock, so a line held low after a
   // framing error can never look like a fresh start edge.
   assign w_fall = r_rx_prev & ~r_rx_s;

   generate
      if (DATA_BITS > 1) begin : g_shift_wide
         assign w_shift_next = {r_rx_s, r_shift[DATA_BITS-1:1]};
      end else begin : g_shift_single
         assign w_shift_next = r_rx_s;
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_meta   <= 1'b1;
         r_rx_s      <= 1'b1;
         r_rx_prev   <= 1'b1;
         r_state     <= c_IDLE;
         r_tick_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_rx_meta   <= rx;
         r_rx_s      <= r_rx_meta;
         r_rx_prev   <= r_rx_s;
         r_valid     <= 1'b0;
         r_frame_err <= 1'b0;

         if (!en) begin
            r_state    <= c_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
         end else begin
            case (r_state)
               c_IDLE: begin
                  if (w_fall) begin
                     r_state    <= c_START;
                     r_tick_cnt <= '0;
                     r_bit_cnt  <= '0;
                  end
               end

               c_START: begin
                  if (baud_tick) begin
                     if (r_tick_cnt == c_TICK_MID) begin
                        r_tick_cnt <= '0;
                        r_bit_cnt  <= '0;
                        // A start bit that is high again at mid-bit was a glitch.
                        r_state    <= r_rx_s ? c_IDLE : c_DATA;
                     end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                     end
                  end
               end

               c_DATA: begin
                  if (baud_tick) begin
                     if (r_tick_cnt == c_TICK_LAST) begin
                        r_tick_cnt <= '0;
                        r_shift    <= w_shift_next;
                        if (r_bit_cnt == c_LAST_BIT) begin
                           r_bit_cnt <= '0;
                           r_state   <= c_STOP;
                        end else begin
                           r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                     end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                     end
                  end
               end

               c_STOP: begin
                  if (baud_tick) begin
                     if (r_tick_cnt == c_TICK_LAST) begin
                        r_tick_cnt  <= '0;
                        r_data      <= r_shift;
                        r_valid     <= r_rx_s;
                        r_frame_err <= ~r_rx_s;
                        r_state     <= c_IDLE;
                     end else begin
                        r_tick_cnt <= r_tick_cnt + 1'b1;
                     end
                  end
               end

               default: begin
                  r_state    <= c_IDLE;
                  r_tick_cnt <= '0;
                  r_bit_cnt  <= '0;
               end
            endcase
         end
      end
   end

   assign data      = r_data;
   assign valid     = r_valid;
   assign frame_err = r_frame_err;
   assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Scoreboard bench for uart_rx: frames are described as
//                (byte, stop level) and the expected result queued per frame.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int DATA_BITS  = 8;
   localparam int OVERSAMPLE = 16;
   localparam int TICK_DIV   = 2;
   localparam int BIT_CLKS   = OVERSAMPLE * TICK_DIV;

   typedef struct {
      logic [7:0] d;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       baud_tick;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   exp_t       exp_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   int         n_pulses = 0;
   int         stray    = 0;
   int         tick_phase = 0;
   logic [7:0] mon_data = 8'h00;
   logic       prev_pulse = 1'b0;

   uart_rx #(
      .DATA_BITS (DATA_BITS),
      .OVERSAMPLE(OVERSAMPLE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .baud_tick(baud_tick),
      .rx       (rx),
      .data     (data),
      .valid    (valid),
      .frame_err(frame_err),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   initial begin
      baud_tick = 1'b0;
      forever begin
         @(negedge clk);
         tick_phase = (tick_phase + 1) % TICK_DIV;
         baud_tick  = (tick_phase == 0);
      end
   end

   initial begin
      #(60000 * 10);
      $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b, input int clks);
      rx = b;
      wait_clks(clks);
   endtask

   // Reference model: a frame yields its data byte, flagged as error when stop is low.
   task automatic send_frame(input logic [7:0] d, input logic stop);
      exp_t e;
      e.d   = d;
      e.err = ~stop;
      exp_q.push_back(e);
      drive_bit(1'b0, BIT_CLKS);
      for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
      drive_bit(stop, BIT_CLKS);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         mon_data   = 8'h00;
         prev_pulse = 1'b0;
      end else begin
         if (valid || frame_err) begin
            n_pulses++;
            check("pulse_width", {31'd0, prev_pulse}, 32'd0);
            check("pulse_expected", {31'd0, (exp_q.size() > 0)}, 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("data", {24'd0, data}, {24'd0, e.d});
               check("valid", {31'd0, valid}, {31'd0, ~e.err});
               check("frame_err", {31'd0, frame_err}, {31'd0, e.err});
               mon_data = e.d;
            end
         end else if (data !== mon_data) begin
            stray++;
         end
         prev_pulse = valid || frame_err;
      end
   end

   initial begin
      int         p0;
      logic [7:0] r;
      logic       stop, last_stop;
      int         gap;

      rst = 1'b1;
      en  = 1'b1;
      rx  = 1'b1;
      wait_clks(3);
      check("reset_data", {24'd0, data}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      wait_clks(2);
      check("post_reset_valid", {31'd0, valid}, 32'd0);
      check("post_reset_frame_err", {31'd0, frame_err}, 32'd0);
      drive_bit(1'b1, BIT_CLKS);

      // Clean frame
      send_frame(8'hB4, 1'b1);
      drive_bit(1'b1, 4);
      check("b4_busy_after", {31'd0, busy}, 32'd0);
      check("b4_pulse_count", n_pulses, 32'd1);

      // Start-bit glitch
      p0 = n_pulses;
      rx = 1'b0;
      wait_clks(6);
      check("glitch_busy_high", {31'd0, busy}, 32'd1);
      wait_clks(2);
      drive_bit(1'b1, 2 * BIT_CLKS);
      check("glitch_busy_low", {31'd0, busy}, 32'd0);
      check("glitch_no_pulse", n_pulses, p0);
      check("glitch_data_hold", {24'd0, data}, 32'h0000_00B4);

      // Framing error, then break held low
      send_frame(8'h5A, 1'b0);
      p0 = n_pulses;
      drive_bit(1'b0, 3 * BIT_CLKS);
      check("break_busy", {31'd0, busy}, 32'd0);
      check("break_no_retrigger", n_pulses, p0);
      drive_bit(1'b1, BIT_CLKS);
      send_frame(8'h3C, 1'b1);

      // Back-to-back frames with no idle gap
      p0 = n_pulses;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      drive_bit(1'b1, BIT_CLKS);
      check("b2b_pulse_count", n_pulses, p0 + 2);

      // Enable dropped during data bit 3 of 8'hC3
      p0 = n_pulses;
      r  = 8'hC3;
      drive_bit(1'b0, BIT_CLKS);
      for (int i = 0; i < 3; i++) drive_bit(r[i], BIT_CLKS);
      drive_bit(r[3], BIT_CLKS / 2);
      en = 1'b0;
      wait_clks(1);
      check("en_drop_busy", {31'd0, busy}, 32'd0);
      rx = 1'b1;
      wait_clks(4);
      en = 1'b1;
      drive_bit(1'b1, 2 * BIT_CLKS);
      check("en_drop_no_pulse", n_pulses, p0);
      check("en_drop_data_hold", {24'd0, data}, 32'h0000_00FF);

      // Asynchronous reset in the middle of a frame
      r = 8'($urandom);
      drive_bit(1'b0, BIT_CLKS);
      for (int i = 0; i < 4; i++) drive_bit(r[i], BIT_CLKS);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("async_rst_data", {24'd0, data}, 32'd0);
      check("async_rst_busy", {31'd0, busy}, 32'd0);
      check("async_rst_valid", {31'd0, valid | frame_err}, 32'd0);
      rx = 1'b1;
      wait_clks(3);
      rst = 1'b0;
      drive_bit(1'b1, BIT_CLKS);
      send_frame(8'h81, 1'b1);

      // Randomized frames with random gaps and occasional bad stop bits
      last_stop = 1'b1;
      for (int k = 0; k < 12; k++) begin
         r    = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         gap  = $urandom_range(0, 2);
         if (!last_stop && gap == 0) gap = 1;
         if (gap > 0) drive_bit(1'b1, gap * BIT_CLKS);
         send_frame(r, stop);
         last_stop = stop;
      end
      drive_bit(1'b1, BIT_CLKS);

      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      check("stray_data_changes", stray, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, number of data bits per frame.
REQ-002 SHALL have parameter OVERSAMPLE, default 16, baud_tick strobes per bit period; even, >=4.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 en  input  1  receiver enable; 0 holds/returns FSM to IDLE.
REQ-006 baud_tick  input  1  one-clk strobe at OVERSAMPLE x baud rate.
REQ-007 rx  input  1  serial line, asynchronous, idle high.
REQ-008 data  output  DATA_BITS  last received byte, LSB = first bit on line.
REQ-009 valid  output  1  one-clk pulse: data holds a correctly framed byte.
REQ-010 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer; all logic uses the synchronized value (rx_s).
REQ-013 Frame format SHALL be 1 start (0), DATA_BITS data LSB first, 1 stop (1), no parity.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 A tick counter (0..OVERSAMPLE-1) SHALL advance only on clocks with baud_tick=1.
REQ-016 IDLE: with en=1, a falling edge of rx_s (previous 1, current 0) SHALL enter START with tick counter cleared.
REQ-017 START: at tick count OVERSAMPLE/2-1 (mid start bit), rx_s=0 -> DATA with counters cleared; rx_s=1 -> IDLE (glitch rejected, no output pulse).
REQ-018 DATA: every OVERSAMPLE ticks SHALL sample rx_s into a shift register (right shift, new bit into MSB); after DATA_BITS samples -> STOP.
REQ-019 STOP: after OVERSAMPLE ticks sample rx_s; 1 -> load data, pulse valid; 0 -> load data, pulse frame_err, valid stays 0; both -> IDLE.
REQ-020 valid/frame_err SHALL assert the clock after the baud_tick clock that samples the stop bit, for exactly one clk.
REQ-021 data SHALL change only when valid or frame_err pulses; otherwise holds.
REQ-022 After frame_err, IDLE SHALL require rx_s to return high before a new falling edge starts a frame (break line does not retrigger).
REQ-023 en=0 in any state SHALL force IDLE on the next clock; partial frame discarded, no pulse, data unchanged.
REQ-024 Back-to-back frames: a start edge arriving in the clock after the stop sample SHALL be accepted.
REQ-025 baud_tick absent SHALL freeze counters and state (except en/rst effects).

Reset
REQ-026 rst=1 SHALL immediately set state IDLE, counters 0, shift register 0, data=0, valid=0, frame_err=0, busy=0, both synchronizer flops=1.
REQ-027 rst mid-frame SHALL discard the frame; after release, reception restarts only on a new falling edge.

Verification
REQ-028 en=1, send 8'hB4 at 16 ticks/bit, stop=1 -> data=8'hB4, valid one clk, frame_err=0, busy low after.
REQ-029 rx low for 4 ticks then high -> busy pulses through START, returns IDLE, no valid/frame_err, data unchanged.
REQ-030 send 8'h5A with stop bit 0 -> frame_err one clk, valid=0, data=8'h5A; rx held low further -> no new frame until rx high then low.
REQ-031 Back-to-back 8'h00 then 8'hFF, no idle gap -> two valid pulses, data 8'h00 then 8'hFF.
REQ-032 en dropped during data bit 3 of 8'hC3 -> IDLE next clk, busy=0, no pulse, data holds previous value.
REQ-033 rst asserted mid-frame (async, between clk edges) -> outputs cleared immediately; subsequent 8'h81 frame received correctly.
